// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and field sizes for the boot loader.
package boot_pkg;
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} stateT;
    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES = 4;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: collects four bytes little-endian into a word, flagging the word on its last byte.
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        wordValid,
    output logic [31:0] word
);
    logic [1:0]  byteIdx;
    logic [23:0] shiftReg;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteIdx  <= '0;
            shiftReg <= '0;
        end else if (byteValid) begin
            byteIdx  <= byteIdx + 2'd1;
            shiftReg <= word[31:8];
        end
    end
    // Newest byte enters at the top so byte 0 ends up in bits [7:0].
    assign word      = {byteIn, shiftReg};
    assign wordValid = byteValid && byteIdx == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed word image into instruction memory, then releases the core.
// Optional BOOT_CHECKSUM_EN adds a trailing mod-2^32 word-sum check.
module boot_loader
    import boot_pkg::*;
#(
    parameter int IMEM_WORDS = 1024,
    parameter int CNT_W      = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);
    stateT state, stateNext;
    logic [CNT_W-1:0] wordCnt, len;
    logic        wordValid, lastWord, restart;
    logic [31:0] word;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum;
`endif

    assign in_ready = rst && (state == S_LEN || state == S_DATA || state == S_CSUM);
    assign done     = state == S_DONE;
    assign error    = state == S_ERR;
    assign lastWord = (wordCnt + CNT_W'(1)) == len;
    assign restart  = reload && (state == S_DONE || state == S_ERR);

    byte_packer packer (
        .clk(clk),
        .rst(rst),
        .byteIn(in_data),
        .byteValid(in_valid && in_ready),
        .wordValid(wordValid),
        .word(word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_LEN;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_LEN:  if (wordValid) stateNext = (word == '0 || word > 32'(IMEM_WORDS)) ? S_ERR : S_DATA;
`ifdef BOOT_CHECKSUM_EN
            S_DATA: if (wordValid && lastWord) stateNext = S_CSUM;
            S_CSUM: if (wordValid) stateNext = (word == sum) ? S_DONE : S_ERR;
`else
            S_DATA: if (wordValid && lastWord) stateNext = S_DONE;
`endif
            S_DONE, S_ERR: if (reload) stateNext = S_LEN;
            default: stateNext = S_LEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wordCnt    <= '0;
            len        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            imem_we  <= 1'b0;
            // Registered release: rises the cycle after DONE entry, drops as soon as reload is seen.
            core_rst <= state == S_DONE && !reload;
            if (restart) begin
                wordCnt <= '0;
                len     <= '0;
`ifdef BOOT_CHECKSUM_EN
                sum     <= '0;
`endif
            end
            if (state == S_LEN && wordValid) len <= word[CNT_W-1:0];
            if (state == S_DATA && wordValid) begin
                imem_we    <= 1'b1;
                imem_addr  <= 32'(wordCnt) << 2;
                imem_wdata <= word;
                wordCnt    <= wordCnt + CNT_W'(1);
`ifdef BOOT_CHECKSUM_EN
                sum        <= sum + word;
`endif
            end
        end
    end
endmodule
